// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns EX-stage taken/link strobes into a registered fetch
// redirect, an IF/ID flush window and a handshaked link-register write request.
module branch_redirect_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int LR_INDEX     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              t_address,
  input  logic              bl_reg,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              lr_wr_req,
  output logic [3:0]        lr_wr_addr,
  output logic [ADDR_W-1:0] lr_wr_data,
  input  logic              lr_wr_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REDIRECT  = 2'd1,
    S_FLUSH     = 2'd2,
    S_LINK_WAIT = 2'd3
  } state_e;

  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              link_pend_q, link_pend_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic [ADDR_W-1:0] lr_wr_data_q, lr_wr_data_d;

  // Next-state, flush counter and link handshake; link_pend_d already reflects this cycle's ack
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_target_d  = pc_target_q;
    lr_wr_data_d = lr_wr_data_q;
    if (link_pend_q && lr_wr_ack) begin
      link_pend_d = 1'b0;
    end else begin
      link_pend_d = link_pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (t_address && !stall) begin
          pc_target_d  = target_addr & ALIGN_MASK;
          lr_wr_data_d = branch_pc + ADDR_W'(4);
          link_pend_d  = bl_reg;
          state_d      = S_REDIRECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_LOAD;
        end else if (link_pend_d) begin
          state_d = S_LINK_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = link_pend_d ? S_LINK_WAIT : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LINK_WAIT: begin
        if (link_pend_d) begin
          state_d = S_LINK_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        link_pend_d = 1'b0;
      end
    endcase
  end

  // State and capture registers; reset abandons any in-flight redirect or link write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      link_pend_q  <= 1'b0;
      pc_target_q  <= '0;
      lr_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      link_pend_q  <= link_pend_d;
      pc_target_q  <= pc_target_d;
      lr_wr_data_q <= lr_wr_data_d;
    end
  end

  assign pc_load    = (state_q == S_REDIRECT);
  assign flush_ifid = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
  assign pc_target  = pc_target_q;
  assign lr_wr_req  = link_pend_q;
  assign lr_wr_addr = link_pend_q ? 4'(LR_INDEX) : 4'd0;
  assign lr_wr_data = lr_wr_data_q;
  assign busy       = (state_q != S_IDLE) || link_pend_q;

endmodule
